// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the multi-cycle shift unit.
// The master side issues operations; the slave side (the shifter) reports status and result.
interface shift_sequencer_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = 5
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [SHW-1:0]  shamt;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, shamt, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, shamt, kill,
    output busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative SLL/SRL/SRA unit: shifts at most STEP bits per cycle until the amount is consumed.
// Result is registered on entry to DONE and held until the next completed operation.
module shift_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = 5,
  parameter int unsigned STEP = 4
) (
  input logic               clk,
  input logic               rst,
  shift_sequencer_if.slave  bus
);
  localparam int unsigned KW = $clog2(STEP + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_shifted;
  logic [XLEN-1:0] result_q;
  logic [SHW-1:0]  cnt;
  logic [SHW-1:0]  cnt_nxt;
  logic [1:0]      op_q;
  logic [KW-1:0]   k;
  logic            pass;

  assign pass = (bus.shamt == '0) || (bus.op == 2'b11);

  // k is kept KW bits wide so the per-cycle shifter only spans 0..STEP positions.
  always_comb begin
    if (cnt > SHW'(STEP)) k = KW'(STEP);
    else                  k = KW'(cnt);
  end

  always_comb begin
    acc_shifted = acc;
    case (op_q)
      2'b00:   acc_shifted = acc << k;
      2'b01:   acc_shifted = acc >> k;
      2'b10:   acc_shifted = XLEN'($signed(acc) >>> k);
      default: acc_shifted = acc;
    endcase
  end

  assign cnt_nxt = cnt - SHW'(k);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = pass ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt_nxt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.kill) state_nxt = IDLE;
  end

  always_comb begin
    bus.busy   = (state == SHIFT);
    bus.done   = (state == DONE);
    bus.result = result_q;
  end

  // kill freezes the datapath; only the state register is redirected to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      op_q     <= 2'b00;
      result_q <= '0;
    end else if (!bus.kill) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc  <= bus.a;
            cnt  <= bus.shamt;
            op_q <= bus.op;
            if (pass) result_q <= bus.a;
          end
        end
        SHIFT: begin
          acc <= acc_shifted;
          cnt <= cnt_nxt;
          if (cnt_nxt == '0) result_q <= acc_shifted;
        end
        default: ;
      endcase
    end
  end
endmodule
